// File: rtl/fila_pkg.sv
// Shared types and constants for the queue dump transmitter: scan FSM states,
// ASCII codes and bit offsets of the fields inside a queue entry.
package fila_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    ENDERECA,
    ESPERA,
    AVALIA,
    ENVIA_ENTRADA,
    ENVIA_FIM,
    CONCLUI
  } estado_t;

  localparam logic [7:0] CHR_O     = 8'h4F;
  localparam logic [7:0] CHR_D     = 8'h44;
  localparam logic [7:0] CHR_ZERO  = 8'h30;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  // Entry layout: {eh_origem, tipo[1:0], origem[1:0], destino[1:0]}
  localparam int EH_ORIGEM_BIT = 6;
  localparam int TIPO_MSB      = 5;
  localparam int ORIGEM_MSB    = 3;
  localparam int DESTINO_MSB   = 1;

  function automatic logic [7:0] digito(input logic [1:0] campo);
    return CHR_ZERO + {6'b0, campo};
  endfunction

endpackage

// File: rtl/fila_serial_tx_if.sv
// Bundle between the dump transmitter, the queue RAM serial read port and
// the control side; the slave modport is the transmitter's view.
interface fila_serial_tx_if #(
    parameter int ADDR_W = 4
);
    import fila_pkg::*;

    logic              start;
    logic [5:0]        dados_addrSerial;
    logic              eh_origem_addrSerial;
    logic [ADDR_W-1:0] addrSerial;
    logic              tx;
    logic              busy;
    logic              pronto;
    logic [ADDR_W:0]   n_entradas;
    estado_t           dbg_estado;

    modport master (
        output start, dados_addrSerial, eh_origem_addrSerial,
        input  addrSerial, tx, busy, pronto, n_entradas, dbg_estado
    );

    modport slave (
        input  start, dados_addrSerial, eh_origem_addrSerial,
        output addrSerial, tx, busy, pronto, n_entradas, dbg_estado
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter, 8N1 or, with FILA_TX_PARITY_EN defined,
// 8E1 (even parity after bit 7). Frames may be chained with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_idle,
    output logic       o_tx
);
`ifdef FILA_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(NBITS);

    logic [NBITS-1:0] r_shift;
    logic [CW-1:0]    r_clk_cnt;
    logic [BW-1:0]    r_bit_idx;
    logic             r_active;

    logic             w_fim_bit;
    logic             w_ultimo;
    logic             w_load;
    logic [NBITS-1:0] w_quadro;

    // Handshake: a byte is taken on a rising edge where i_valid && o_ready.
    // o_ready is high when idle and also during the final cycle of the stop
    // bit, so a waiting byte starts its start bit with no gap.
    assign w_fim_bit = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_ultimo  = w_fim_bit && (r_bit_idx == BW'(NBITS - 1));
    assign o_ready   = !r_active || w_ultimo;
    assign w_load    = o_ready && i_valid;
    assign o_idle    = !r_active;
    assign o_tx      = r_active ? r_shift[0] : 1'b1;

`ifdef FILA_TX_PARITY_EN
    assign w_quadro = {1'b1, ^i_data, i_data, 1'b0};
`else
    assign w_quadro = {1'b1, i_data, 1'b0};
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_active  <= 1'b0;
            r_shift   <= '1;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
        end else if (w_load) begin
            r_active  <= 1'b1;
            r_shift   <= w_quadro;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
        end else if (r_active) begin
            if (w_fim_bit) begin
                r_clk_cnt <= '0;
                if (w_ultimo) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_idx <= r_bit_idx + BW'(1);
                    r_shift   <= {1'b1, r_shift[NBITS-1:1]};
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fila_serial_tx.sv
// Read-only dump of the request queue over UART: scans entries until the
// first empty one, sends each as "Xtod " then CR LF. FILA_TX_PARITY_EN adds parity.
module fila_serial_tx
    import fila_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    fila_serial_tx_if.slave   bus
);
    estado_t           r_estado, w_prox;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   r_cont;
    logic [ADDR_W:0]   r_n_entradas;
    logic [6:0]        r_entry;
    logic [2:0]        r_chr;

    logic [6:0] w_entrada;
    logic       w_vazia;
    logic       w_ultima;
    logic       w_busy, w_pronto, w_valid, w_ready, w_idle, w_aceito;
    logic [7:0] w_byte;

    assign w_entrada = {bus.eh_origem_addrSerial, bus.dados_addrSerial};
    assign w_vazia   = (w_entrada == 7'b0);
    assign w_ultima  = (r_index == ADDR_W'(DEPTH - 1));
    assign w_aceito  = w_valid && w_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) r_estado <= OCIOSO;
        else          r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:        if (bus.start) w_prox = ENDERECA;
            ENDERECA:      w_prox = ESPERA;
            ESPERA:        w_prox = AVALIA;
            AVALIA:        w_prox = w_vazia ? ENVIA_FIM : ENVIA_ENTRADA;
            ENVIA_ENTRADA: if (w_aceito && r_chr == 3'd4) w_prox = w_ultima ? ENVIA_FIM : ENDERECA;
            ENVIA_FIM:     if (r_chr == 3'd2 && w_idle) w_prox = CONCLUI;
            CONCLUI:       w_prox = OCIOSO;
            default:       w_prox = OCIOSO;
        endcase
    end

    always_comb begin
        w_busy   = 1'b1;
        w_pronto = 1'b0;
        w_valid  = 1'b0;
        w_byte   = CHR_SPACE;
        case (r_estado)
            OCIOSO:        w_busy = 1'b0;
            ENVIA_ENTRADA: begin
                w_valid = 1'b1;
                case (r_chr)
                    3'd0:    w_byte = r_entry[EH_ORIGEM_BIT] ? CHR_O : CHR_D;
                    3'd1:    w_byte = digito(r_entry[TIPO_MSB -: 2]);
                    3'd2:    w_byte = digito(r_entry[ORIGEM_MSB -: 2]);
                    3'd3:    w_byte = digito(r_entry[DESTINO_MSB -: 2]);
                    default: w_byte = CHR_SPACE;
                endcase
            end
            ENVIA_FIM: begin
                w_valid = (r_chr < 3'd2);
                w_byte  = r_chr[0] ? CHR_LF : CHR_CR;
            end
            CONCLUI: begin
                w_busy   = 1'b0;
                w_pronto = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan datapath; the entry is latched from live RAM data at AVALIA.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_index      <= '0;
            r_cont       <= '0;
            r_n_entradas <= '0;
            r_entry      <= '0;
            r_chr        <= '0;
        end else begin
            case (r_estado)
                OCIOSO: if (bus.start) begin
                    r_index <= '0;
                    r_cont  <= '0;
                end
                AVALIA: begin
                    r_entry <= w_entrada;
                    r_chr   <= '0;
                    if (!w_vazia && r_cont != (ADDR_W+1)'(DEPTH)) r_cont <= r_cont + 1'b1;
                end
                ENVIA_ENTRADA: if (w_aceito) begin
                    if (r_chr == 3'd4) begin
                        r_chr <= '0;
                        if (!w_ultima) r_index <= r_index + ADDR_W'(1);
                    end else begin
                        r_chr <= r_chr + 3'd1;
                    end
                end
                ENVIA_FIM: begin
                    if (w_aceito) r_chr <= r_chr + 3'd1;
                    if (r_chr == 3'd2 && w_idle) r_n_entradas <= r_cont;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk     (clk),
        .clear_n (clear_n),
        .i_data  (w_byte),
        .i_valid (w_valid),
        .o_ready (w_ready),
        .o_idle  (w_idle),
        .o_tx    (bus.tx)
    );

    assign bus.addrSerial = r_index;
    assign bus.busy       = w_busy;
    assign bus.pronto     = w_pronto;
    assign bus.n_entradas = r_n_entradas;
    assign bus.dbg_estado = r_estado;

endmodule

// File: doc/fila_serial_tx.md
Name: fila_serial_tx

Overview:
- Reader end of the SmartCargo request queue: walks the 16-entry queue RAM through its serial read port (addrSerial / dados_addrSerial / eh_origem_addrSerial).
- Formats each occupied entry as ASCII and transmits it over an 8N1 UART line for the debug/monitor link.
- Never writes the queue.
- Sits beside the queue RAM, triggered by the control unit or a debug button.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- DEPTH, 16, number of queue entries scanned.
- ADDR_W, 4, queue address width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse requesting a queue dump.
- dados_addrSerial  in  6  {tipo[5:4], origem[3:2], destino[1:0]} of the addressed entry.
- eh_origem_addrSerial  in  1  bit 6 of the addressed entry.
- addrSerial  out  ADDR_W  queue read address.
- tx  out  1  UART line; idles high.
- busy  out  1  high from accepted start until the last stop bit ends.
- pronto  out  1  one-cycle pulse after the final character.
- n_entradas  out  ADDR_W+1  count of occupied entries found in the last dump.

Behaviour:
- Reset (async, clear_n=0):
  - State OCIOSO; tx=1, busy=0, pronto=0, addrSerial=0, n_entradas=0.
  - Any frame in flight is abandoned immediately; no partial character is completed.
- start:
  - Sampled only in OCIOSO; ignored while busy=1.
  - On acceptance: busy=1 the next cycle, index=0, entry counter=0.
- Read latency:
  - The RAM registers addrSerial.
  - Data is sampled on the second rising edge after addrSerial changes (ENDERECA -> ESPERA -> AVALIA).
  - addrSerial is held stable during that interval.
- Empty entry: {eh_origem, dados} == 7'b0.
  - The queue is head-compacted, so the first empty entry ends the scan.
- Occupied entry is sent as 5 characters, in order:
  - 'O' if eh_origem else 'D';
  - '0'+tipo;
  - '0'+origem;
  - '0'+destino;
  - ' '.
- End of dump: after the first empty entry, or after entry DEPTH-1 if all are occupied, send CR (0x0D) then LF (0x0A).
  - An empty queue sends only CR LF.
  - The index does not wrap.
- FSM:
  - OCIOSO -> ENDERECA on start.
  - ENDERECA -> ESPERA -> AVALIA.
  - AVALIA: occupied -> ENVIA_ENTRADA; empty -> ENVIA_FIM.
  - ENVIA_ENTRADA: after the 5th character, index==DEPTH-1 -> ENVIA_FIM; else index+1 -> ENDERECA.
  - ENVIA_FIM: after LF -> CONCLUI.
  - CONCLUI: pronto=1 and n_entradas updated (same cycle), busy=0, then OCIOSO.
- Live data: entries are not snapshotted; each entry is sampled at its own AVALIA.
  - Concurrent shift/fit/weT may make the dump inconsistent. This is accepted; control must hold the queue if consistency is needed.
- UART frame: start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Characters are back-to-back, with no idle gap between stop and next start.
- Width rule: n_entradas saturates at DEPTH; digit = 8'h30 + zero-extended 2-bit field.

Optional Feature:
- FILA_TX_PARITY_EN
  - Defined: an even-parity bit is inserted after bit 7 (11-bit frame); all timing is otherwise unchanged.
  - Undefined: 8N1 as above; no parity logic synthesised.

Decomposition:
- Package fila_pkg:
  - FSM state enum;
  - ASCII constants (CHR_O, CHR_D, CHR_ZERO, CHR_SPACE, CHR_CR, CHR_LF);
  - entry field bit offsets (EH_ORIGEM_BIT=6, TIPO_MSB=5, ORIGEM_MSB=3, DESTINO_MSB=1).
- Sub-module uart_tx_byte:
  - Handles byte load/valid/ready handshake, bit-period counter, shift register and optional parity.
  - fila_serial_tx owns only the scan FSM and the character sequencer.

Test Plan (bench CLKS_PER_BIT=4):
- Reset while transmitting mid-bit: clear_n low -> tx=1, busy=0 in the same cycle; no further edges on tx.
- Empty queue, start: bytes 0x0D, 0x0A only; pronto pulses once; n_entradas=0; addrSerial only visits 0.
- Entry0 = {0,2,1,3}, entry1 empty: bytes "D213 " then CR LF; n_entradas=1. Check that data is sampled exactly 2 edges after addrSerial=0.
- Entry0 = {1,1,2,2}, entry1 = {0,3,0,1}: bytes "O122 D301 " CR LF; n_entradas=2; each bit is exactly 4 cycles long; frames are back-to-back.
- All 16 entries occupied: 80 entry bytes + CR LF; addrSerial stops at 15 with no wrap; n_entradas=16. A second start pulsed while busy is ignored.
- With FILA_TX_PARITY_EN: byte 'D' (0x44) carries parity bit 0; byte '1' (0x31) carries parity bit 1. Frame length is 11 bits.
